// File: rtl/vecgen_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : vecgen_pkg                                                 |
// | Description : Shared widths and helper functions for the tile motion     |
// |               detector (tile geometry, luma, counter widths).            |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
package vecgen_pkg;

   // Per-tile luma sum: 3600 pixels * 255 fits in 20 bits.
   localparam int ACC_W = 20;
   // Tile signature width.
   localparam int SIG_W = 8;

   // Size of one tile along an axis (caller checks divisibility).
   function automatic int tile_dim(input int total, input int count);
      return total / count;
   endfunction

   // Counter width for a range of v values, never narrower than one bit.
   function automatic int width_of(input int v);
      return (v > 1) ? $clog2(v) : 1;
   endfunction

   // Luma approximation Y = (R + 2G + B) >> 2.
   function automatic logic [7:0] luma(input logic [23:0] px);
      logic [9:0] s;
      s = {2'b00, px[23:16]} + {1'b0, px[15:8], 1'b0} + {2'b00, px[7:0]};
      return s[9:2];
   endfunction

endpackage
`default_nettype wire

// File: rtl/vecgen_sigmem.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : vecgen_sigmem                                              |
// | Description : Single-port tile signature RAM, synchronous read-first,    |
// |               one cycle read latency; maps onto a block RAM.             |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module vecgen_sigmem
   import vecgen_pkg::*;
#(
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 8,
   parameter int DATA_W = SIG_W
) (
   input  logic              pclk,
   input  logic              i_en,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];

   // Read-first: the old signature comes out while the new one is stored.
   always_ff @(posedge pclk) begin
      if (i_en) begin
         o_rdata <= r_mem[i_addr];
         if (i_we) begin
            r_mem[i_addr] <= i_wdata;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/vecgen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : vecgen                                                     |
// | Description : Coarse per-tile motion detector. Sums luma over a GX x GY  |
// |               tile grid, compares each tile signature with the previous  |
// |               frame and strobes tile index plus motion flag.             |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module vecgen
   import vecgen_pkg::*;
#(
   parameter int H_ACTIVE      = 1280,
   parameter int V_ACTIVE      = 720,
   parameter int GX            = 16,
   parameter int GY            = 16,
   parameter int SUM_SHIFT     = 12,
   parameter int MOTION_THRESH = 16
) (
   input  logic                          pclk,
   input  logic                          rst,
   input  logic [23:0]                   s_pData,
   input  logic                          s_pVDE,
   input  logic                          s_pHSync,
   input  logic                          s_pVSync,
   output logic                          vec_we,
   output logic [width_of(GX*GY)-1:0]    vec_addr,
   output logic                          motion_detected
);

   localparam int TILE_W = tile_dim(H_ACTIVE, GX);
   localparam int TILE_H = tile_dim(V_ACTIVE, GY);
   localparam int ADDR_W = width_of(GX*GY);
   localparam int TX_W   = width_of(GX);
   localparam int TY_W   = width_of(GY);
   localparam int COL_W  = width_of(TILE_W);
   localparam int BL_W   = width_of(TILE_H);

   localparam logic [COL_W-1:0] c_COL_LAST = COL_W'(TILE_W - 1);
   localparam logic [TX_W-1:0]  c_TX_LAST  = TX_W'(GX - 1);
   localparam logic [TY_W-1:0]  c_TY_LAST  = TY_W'(GY - 1);
   localparam logic [BL_W-1:0]  c_BL_LAST  = BL_W'(TILE_H - 1);
   localparam logic [SIG_W-1:0] c_THRESH   = SIG_W'(MOTION_THRESH);

   if ((H_ACTIVE % GX) != 0) begin : g_bad_tile_w
      $error("vecgen: H_ACTIVE must be a multiple of GX");
   end
   if ((V_ACTIVE % GY) != 0) begin : g_bad_tile_h
      $error("vecgen: V_ACTIVE must be a multiple of GY");
   end

   // Sync inputs are reserved; timing comes from VDE alone.
   logic w_unused_sync;
   assign w_unused_sync = s_pHSync ^ s_pVSync;

   // Raster position, tracked as (tile column, column within tile).
   logic              r_vde_d;
   logic [COL_W-1:0]  r_col;
   logic [TX_W-1:0]   r_tx;
   logic              r_ovf;
   logic [BL_W-1:0]   r_bline;
   logic [TY_W-1:0]   r_ty;

   logic              w_line_end;
   logic              w_band_end;
   logic              w_frame_end;
   logic              w_pix_act;
   logic [7:0]        w_luma;

   assign w_line_end  = r_vde_d & ~s_pVDE;
   assign w_band_end  = w_line_end & (r_bline == c_BL_LAST);
   assign w_frame_end = w_band_end & (r_ty == c_TY_LAST);
   assign w_pix_act   = s_pVDE & ~r_ovf;
   assign w_luma      = luma(s_pData);

   // Raster counters: column/tile advance on active pixels, rows on line end.
   always_ff @(posedge pclk or negedge rst) begin
      if (!rst) begin
         r_vde_d <= 1'b0;
         r_col   <= '0;
         r_tx    <= '0;
         r_ovf   <= 1'b0;
         r_bline <= '0;
         r_ty    <= '0;
      end else begin
         r_vde_d <= s_pVDE;
         if (w_line_end) begin
            r_col <= '0;
            r_tx  <= '0;
            r_ovf <= 1'b0;
            if (w_band_end) begin
               r_bline <= '0;
               r_ty    <= (r_ty == c_TY_LAST) ? '0 : r_ty + TY_W'(1);
            end else begin
               r_bline <= r_bline + BL_W'(1);
            end
         end else if (w_pix_act) begin
            if (r_col == c_COL_LAST) begin
               r_col <= '0;
               if (r_tx == c_TX_LAST) begin
                  r_ovf <= 1'b1;
               end else begin
                  r_tx <= r_tx + TX_W'(1);
               end
            end else begin
               r_col <= r_col + COL_W'(1);
            end
         end
      end
   end

   // Per-column running sums plus the bank holding the finished band.
   logic [ACC_W-1:0] r_acc  [GX];
   logic [ACC_W-1:0] r_hold [GX];

   // Accumulate luma; at band end hand sums to the holding bank and restart.
   always_ff @(posedge pclk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < GX; i++) begin
            r_acc[i]  <= '0;
            r_hold[i] <= '0;
         end
      end else begin
         for (int i = 0; i < GX; i++) begin
            if (w_band_end) begin
               r_hold[i] <= r_acc[i];
               r_acc[i]  <= '0;
            end else if (w_pix_act && (r_tx == TX_W'(i))) begin
               r_acc[i] <= r_acc[i] + ACC_W'(w_luma);
            end
         end
      end
   end

   // Emission walker over the held band.
   logic              r_emit;
   logic [TX_W-1:0]   r_etx;
   logic [TY_W-1:0]   r_ety;
   logic              r_emit_pv;
   logic              r_prev_valid;

   // Start a GX-long walk at each band end; previous frame becomes valid at frame end.
   always_ff @(posedge pclk or negedge rst) begin
      if (!rst) begin
         r_emit       <= 1'b0;
         r_etx        <= '0;
         r_ety        <= '0;
         r_emit_pv    <= 1'b0;
         r_prev_valid <= 1'b0;
      end else begin
         if (w_band_end) begin
            r_emit    <= 1'b1;
            r_etx     <= '0;
            r_ety     <= r_ty;
            // Sampled before the frame-end update so the last band of the
            // first frame still reports no motion.
            r_emit_pv <= r_prev_valid;
         end else if (r_emit) begin
            if (r_etx == c_TX_LAST) begin
               r_emit <= 1'b0;
            end else begin
               r_etx <= r_etx + TX_W'(1);
            end
         end
         if (w_frame_end) begin
            r_prev_valid <= 1'b1;
         end
      end
   end

   logic [ADDR_W-1:0] w_idx;
   logic [ACC_W-1:0]  w_hold_sel;
   logic [ACC_W-1:0]  w_shift;
   logic [SIG_W-1:0]  w_sig;
   logic [SIG_W-1:0]  w_prev;

   assign w_idx      = ADDR_W'(int'(r_ety) * GX + int'(r_etx));
   assign w_hold_sel = r_hold[r_etx];
   assign w_shift    = w_hold_sel >> SUM_SHIFT;
   assign w_sig      = (|w_shift[ACC_W-1:SIG_W]) ? '1 : w_shift[SIG_W-1:0];

   vecgen_sigmem #(
      .DEPTH  (GX*GY),
      .ADDR_W (ADDR_W),
      .DATA_W (SIG_W)
   ) u_sigmem (
      .pclk    (pclk),
      .i_en    (r_emit),
      .i_we    (r_emit),
      .i_addr  (w_idx),
      .i_wdata (w_sig),
      .o_rdata (w_prev)
   );

   // Stage aligned with the RAM read data.
   logic              r_s_vld;
   logic [ADDR_W-1:0] r_s_idx;
   logic [SIG_W-1:0]  r_s_sig;
   logic              r_s_pv;
   logic [SIG_W-1:0]  w_diff;

   assign w_diff = (r_s_sig > w_prev) ? (r_s_sig - w_prev) : (w_prev - r_s_sig);

   // Compare against the stored signature and register the strobe outputs.
   always_ff @(posedge pclk or negedge rst) begin
      if (!rst) begin
         r_s_vld         <= 1'b0;
         r_s_idx         <= '0;
         r_s_sig         <= '0;
         r_s_pv          <= 1'b0;
         vec_we          <= 1'b0;
         vec_addr        <= '0;
         motion_detected <= 1'b0;
      end else begin
         r_s_vld <= r_emit;
         r_s_idx <= w_idx;
         r_s_sig <= w_sig;
         r_s_pv  <= r_emit_pv;
         vec_we  <= r_s_vld;
         if (r_s_vld) begin
            vec_addr        <= r_s_idx;
            motion_detected <= r_s_pv & (w_diff > c_THRESH);
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_vecgen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_vecgen                                                  |
// | Description : Self-checking bench for vecgen on a reduced 64x48 raster   |
// |               with a 16x16 tile grid and a frame-level reference model.  |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module tb_vecgen;

   localparam int H     = 64;
   localparam int V     = 48;
   localparam int NGX   = 16;
   localparam int NGY   = 16;
   localparam int SHIFT = 3;
   localparam int THR   = 16;
   localparam int TW    = H / NGX;
   localparam int TH    = V / NGY;

   localparam int K_HALF  = 0;
   localparam int K_BLACK = 1;
   localparam int K_T37   = 2;
   localparam int K_RAND  = 3;

   logic        pclk = 1'b0;
   logic        rst = 1'b0;
   logic [23:0] s_pData = 24'h0;
   logic        s_pVDE = 1'b0;
   logic        s_pHSync = 1'b0;
   logic        s_pVSync = 1'b0;
   logic        vec_we;
   logic [7:0]  vec_addr;
   logic        motion_detected;

   vecgen #(
      .H_ACTIVE      (H),
      .V_ACTIVE      (V),
      .GX            (NGX),
      .GY            (NGY),
      .SUM_SHIFT     (SHIFT),
      .MOTION_THRESH (THR)
   ) dut (
      .pclk            (pclk),
      .rst             (rst),
      .s_pData         (s_pData),
      .s_pVDE          (s_pVDE),
      .s_pHSync        (s_pHSync),
      .s_pVSync        (s_pVSync),
      .vec_we          (vec_we),
      .vec_addr        (vec_addr),
      .motion_detected (motion_detected)
   );

   always #5 pclk = ~pclk;

   typedef struct {
      int     addr;
      bit     mot;
      longint edge_no;
   } exp_t;

   exp_t       q[$];
   longint     edge_n = 0;
   int         total = 0;
   int         bad = 0;
   int         n_strobe = 0;
   int         n_flag = 0;
   int         prev_sig [NGX*NGY];
   int         tsum [NGX];
   bit         pv = 1'b0;
   int         last_addr = 0;
   bit         last_mot = 1'b0;
   logic [7:0] t37_val = 8'h00;

   always @(posedge pclk) edge_n <= edge_n + 1;

   task automatic check(input string tag, input longint obs, input longint expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // Output monitor: every strobe must match the head of the expected queue.
   always @(posedge pclk) begin
      exp_t e;
      #1;
      if (!rst) begin
         check("rst_we", vec_we, 0);
         check("rst_addr", vec_addr, 0);
         check("rst_mot", motion_detected, 0);
         last_addr = 0;
         last_mot  = 1'b0;
      end else if (vec_we) begin
         n_strobe++;
         if (motion_detected) n_flag++;
         check("strobe_expected", q.size() > 0, 1);
         if (q.size() > 0) begin
            e = q.pop_front();
            check("strobe_addr", vec_addr, e.addr);
            check("strobe_motion", motion_detected, e.mot);
            check("strobe_cycle", edge_n, e.edge_no);
         end
         last_addr = vec_addr;
         last_mot  = motion_detected;
      end else begin
         check("hold_addr", vec_addr, last_addr);
         check("hold_mot", motion_detected, last_mot);
         if (q.size() > 0 && q[0].edge_no <= edge_n) begin
            check("strobe_missing", vec_we, 1);
            void'(q.pop_front());
         end
      end
   end

   task automatic drive(input bit vde, input logic [23:0] d);
      @(negedge pclk);
      s_pVDE  = vde;
      s_pData = d;
   endtask

   function automatic int luma_of(input logic [23:0] p);
      return (int'(p[23:16]) + 2 * int'(p[15:8]) + int'(p[7:0])) / 4;
   endfunction

   function automatic logic [23:0] pixel_of(input int kind, input int x, input int y);
      case (kind)
         K_HALF:  return (x > H / 2) ? 24'hFFFFFF : 24'h000000;
         K_T37:   return (((y / TH) * NGX + x / TW) == 37) ? {3{t37_val}} : 24'h000000;
         K_RAND:  return 24'($urandom);
         default: return 24'h000000;
      endcase
   endfunction

   // Drive nlines lines of a frame; each completed band queues GX expected strobes.
   task automatic drive_frame(input int kind, input int nlines);
      int          len;
      int          nblank;
      int          ty;
      int          idx;
      int          sig;
      int          d;
      logic [23:0] p;
      for (int y = 0; y < nlines; y++) begin
         len = (kind == K_RAND) ? H + int'($urandom_range(0, 2)) : H;
         for (int x = 0; x < len; x++) begin
            p = pixel_of(kind, x, y);
            drive(1'b1, p);
            if (x < H) tsum[x / TW] += luma_of(p);
         end
         nblank = (kind == K_RAND) ? int'($urandom_range(1, 3)) : 1;
         drive(1'b0, 24'($urandom));
         if (((y + 1) % TH) == 0) begin
            ty = y / TH;
            for (int tx = 0; tx < NGX; tx++) begin
               idx = ty * NGX + tx;
               sig = tsum[tx] >> SHIFT;
               if (sig > 255) sig = 255;
               d = sig - prev_sig[idx];
               if (d < 0) d = -d;
               q.push_back('{idx, pv && (d > THR), edge_n + 3 + tx});
               prev_sig[idx] = sig;
               tsum[tx] = 0;
            end
            if (ty == NGY - 1) pv = 1'b1;
         end
         for (int b = 1; b < nblank; b++) drive(1'b0, 24'($urandom));
      end
   endtask

   task automatic finish_frame(input string tag, input int exp_flag, input bit chk_flag);
      int guard;
      guard = 0;
      repeat (NGX + 4) drive(1'b0, 24'h0);
      while (q.size() > 0 && guard < 200) begin
         drive(1'b0, 24'h0);
         guard++;
      end
      check({tag, "_drained"}, q.size(), 0);
      check({tag, "_strobes"}, n_strobe, NGX * NGY);
      if (chk_flag) check({tag, "_flags"}, n_flag, exp_flag);
      n_strobe = 0;
      n_flag   = 0;
   endtask

   task automatic do_reset(input int cycles);
      @(negedge pclk);
      rst     = 1'b0;
      s_pVDE  = 1'b0;
      s_pData = 24'h0;
      q.delete();
      pv = 1'b0;
      foreach (tsum[i]) tsum[i] = 0;
      repeat (cycles) @(negedge pclk);
      n_strobe = 0;
      n_flag   = 0;
      rst = 1'b1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      foreach (prev_sig[i]) prev_sig[i] = 0;
      foreach (tsum[i]) tsum[i] = 0;
      do_reset(8);

      drive_frame(K_HALF, V);
      finish_frame("f1_half_first", 0, 1'b1);
      drive_frame(K_BLACK, V);
      finish_frame("f2_black", 128, 1'b1);
      drive_frame(K_BLACK, V);
      finish_frame("f3_static", 0, 1'b1);

      t37_val = 8'h20;
      drive_frame(K_T37, V);
      finish_frame("f4_t37_on", 1, 1'b1);
      t37_val = 8'h00;
      drive_frame(K_T37, V);
      finish_frame("f5_t37_off", 1, 1'b1);
      t37_val = 8'h0B;
      drive_frame(K_T37, V);
      finish_frame("f6_t37_at_thresh", 0, 1'b1);

      drive_frame(K_RAND, V);
      finish_frame("f7_rand", 0, 1'b0);
      drive_frame(K_RAND, V);
      finish_frame("f8_rand", 0, 1'b0);

      drive_frame(K_RAND, 20);
      do_reset(5);
      drive_frame(K_BLACK, V);
      finish_frame("f9_post_reset", 0, 1'b1);
      drive_frame(K_HALF, V);
      finish_frame("f10_half", 128, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
